// File: rtl/uart_tx_pkg.sv
// Shared UART TX definitions: one-hot frame states, line levels and parity encodings.
package uart_tx_pkg;

  typedef logic [4:0] state_t;

  localparam state_t S_IDLE   = 5'b00001;
  localparam state_t S_START  = 5'b00010;
  localparam state_t S_DATA   = 5'b00100;
  localparam state_t S_PARITY = 5'b01000;
  localparam state_t S_STOP   = 5'b10000;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Value XORed onto the data reduction so that odd parity inverts the bit.
  function automatic logic par_seed(input logic typ);
    case (typ)
      PAR_ODD:  return 1'b1;
      PAR_EVEN: return 1'b0;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Registered parity generator; loads parity bit and parity enable on the accept cycle.
// One cycle latency from i_load; holds its value for the rest of the frame.
module uart_tx_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  output logic                  o_par_bit,
  output logic                  o_par_en
);

  logic r_par_bit;
  logic r_par_en;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_par_bit <= 1'b0;
      r_par_en  <= 1'b0;
    end else if (i_load) begin
      r_par_bit <= (^i_data) ^ par_seed(i_par_typ);
      r_par_en  <= i_par_en;
    end
  end

  assign o_par_bit = r_par_bit;
  assign o_par_en  = r_par_en;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: sequences start/data/parity/stop around an external serializer.
// Offers are taken only in IDLE (busy=0); offers while busy are dropped, TX_OUT is a pure state mux.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Data_Valid,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_en,
  output logic                  busy,
  output logic                  TX_OUT
);

  state_t r_state;
  state_t w_next;
  logic   r_stop_cnt;
  logic   w_accept;
  logic   w_stop_last;
  logic   w_par_bit;
  logic   w_par_en;

  assign w_accept    = Data_Valid && (r_state == S_IDLE);
  assign w_stop_last = (r_stop_cnt == 1'(STOP_BITS - 1));

  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .CLK       (CLK),
    .RST       (RST),
    .i_load    (w_accept),
    .i_data    (P_DATA),
    .i_par_en  (PAR_EN),
    .i_par_typ (PAR_TYP),
    .o_par_bit (w_par_bit),
    .o_par_en  (w_par_en)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (Data_Valid) w_next = S_START;
      S_START:  w_next = S_DATA;
      S_DATA:   if (ser_done) w_next = w_par_en ? S_PARITY : S_STOP;
      S_PARITY: w_next = S_STOP;
      S_STOP:   if (w_stop_last) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_stop_cnt <= 1'b0;
    end else begin
      r_state <= w_next;
      // Counter idles at zero so every STOP phase starts from a clean count.
      if ((r_state == S_STOP) && !w_stop_last) r_stop_cnt <= r_stop_cnt + 1'b1;
      else                                     r_stop_cnt <= 1'b0;
    end
  end

  assign busy = (r_state != S_IDLE);

  always_comb begin
    ser_en = 1'b0;
    TX_OUT = IDLE_LEVEL;
    case (r_state)
      S_START: begin
        ser_en = 1'b1;
        TX_OUT = START_BIT;
      end
      S_DATA: begin
        ser_en = !ser_done;
        TX_OUT = ser_data;
      end
      S_PARITY: TX_OUT = w_par_bit;
      S_STOP:   TX_OUT = STOP_BIT;
      default:  TX_OUT = IDLE_LEVEL;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench: two controllers (1 and 2 stop bits) each with a behavioural serializer.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Data_Valid;
  logic [7:0] P_DATA;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [1:0] ser_data;
  logic [1:0] ser_done;
  logic [1:0] ser_en;
  logic [1:0] busy;
  logic [1:0] tx;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) dut0 (
    .CLK(CLK), .RST(RST), .Data_Valid(Data_Valid), .P_DATA(P_DATA),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_data(ser_data[0]), .ser_done(ser_done[0]),
    .ser_en(ser_en[0]), .busy(busy[0]), .TX_OUT(tx[0])
  );

  uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) dut1 (
    .CLK(CLK), .RST(RST), .Data_Valid(Data_Valid), .P_DATA(P_DATA),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_data(ser_data[1]), .ser_done(ser_done[1]),
    .ser_en(ser_en[1]), .busy(busy[1]), .TX_OUT(tx[1])
  );

  // Behavioural serializer: loads while idle, shifts LSB first on each ser_en.
  logic [7:0] sh  [2];
  int         idx [2];

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 2; i++) begin
        idx[i]      <= 0;
        ser_data[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!busy[i]) begin
          sh[i]  <= P_DATA;
          idx[i] <= 0;
        end else if (ser_en[i] && idx[i] < 8) begin
          ser_data[i] <= sh[i][idx[i]];
          idx[i]      <= idx[i] + 1;
        end
      end
    end
  end

  always_comb begin
    ser_done = '0;
    for (int i = 0; i < 2; i++) ser_done[i] = (idx[i] == 8);
  end

  // Line recorder: every busy cycle's TX level, ser_en cycles and frame starts.
  logic q0[$];
  logic q1[$];
  int   en_cnt0  = 0;
  int   en_cnt1  = 0;
  int   n_start0 = 0;
  logic prev_b0  = 1'b0;

  always @(posedge CLK) begin
    #1;
    if (busy[0]) q0.push_back(tx[0]);
    if (busy[1]) q1.push_back(tx[1]);
    if (ser_en[0]) en_cnt0++;
    if (ser_en[1]) en_cnt1++;
    if (busy[0] && !prev_b0) n_start0++;
    prev_b0 = busy[0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic frame(input logic [7:0] b, input logic pe, input logic pt);
    P_DATA     = b;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy != 2'b00 && n < 40) begin
      tick();
      n++;
    end
    if (busy != 2'b00) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] bits_of(input int which, input int from);
    logic [31:0] r;
    int          n;
    r = '0;
    n = (which == 0) ? q0.size() : q1.size();
    for (int k = from; k < n; k++) r = {r[30:0], (which == 0) ? q0[k] : q1[k]};
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b0, b1, e0, e1, s0;
    logic [20:0] tx_seq;
    logic [20:0] bz_seq;

    RST = 1'b1; Data_Valid = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ser_en", 32'(ser_en), 32'd0);
    chk("rst_tx", 32'(tx), 32'd3);
    #2 RST = 1'b0;
    tick(); tick();

    // 0xA5, no parity
    b0 = q0.size(); b1 = q1.size(); e0 = en_cnt0; e1 = en_cnt1;
    frame(8'hA5, 1'b0, 1'b0);
    wait_idle();
    chk("a5_np_len0", q0.size() - b0, 10);
    chk("a5_np_bits0", bits_of(0, b0), 32'b0101001011);
    chk("a5_np_len1", q1.size() - b1, 11);
    chk("a5_np_bits1", bits_of(1, b1), 32'b01010010111);
    chk("a5_np_sen0", en_cnt0 - e0, 8);
    chk("a5_np_sen1", en_cnt1 - e1, 8);
    tick();

    // 0xA5, even parity
    b0 = q0.size(); b1 = q1.size();
    frame(8'hA5, 1'b1, 1'b0);
    wait_idle();
    chk("a5_even_len0", q0.size() - b0, 11);
    chk("a5_even_bits0", bits_of(0, b0), 32'b01010010101);
    chk("a5_even_slot0", 32'(q0[b0 + 9]), 32'd0);
    chk("a5_even_bits1", bits_of(1, b1), 32'b010100101011);
    tick();

    // 0xA5, odd parity
    b0 = q0.size(); b1 = q1.size();
    frame(8'hA5, 1'b1, 1'b1);
    wait_idle();
    chk("a5_odd_len0", q0.size() - b0, 11);
    chk("a5_odd_bits0", bits_of(0, b0), 32'b01010010111);
    chk("a5_odd_len1", q1.size() - b1, 12);
    chk("a5_odd_bits1", bits_of(1, b1), 32'b010100101111);
    tick();

    // 0x07 even parity, PAR_TYP/PAR_EN flipped mid-frame
    b0 = q0.size(); b1 = q1.size();
    frame(8'h07, 1'b1, 1'b0);
    tick(); tick(); tick();
    PAR_TYP = 1'b1;
    PAR_EN  = 1'b0;
    wait_idle();
    chk("p07_slot0", 32'(q0[b0 + 9]), 32'd1);
    chk("p07_bits0", bits_of(0, b0), 32'b01110000011);
    chk("p07_bits1", bits_of(1, b1), 32'b011100000111);
    tick();

    // 0xFF with a stray offer of 0x3C during DATA
    b0 = q0.size(); b1 = q1.size(); s0 = n_start0;
    frame(8'hFF, 1'b0, 1'b0);
    tick(); tick(); tick();
    P_DATA = 8'h3C; Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
    wait_idle();
    chk("ff_len0", q0.size() - b0, 10);
    chk("ff_bits0", bits_of(0, b0), 32'b0111111111);
    chk("ff_bits1", bits_of(1, b1), 32'b01111111111);
    repeat (4) tick();
    chk("ff_no_restart_busy", 32'(busy), 32'd0);
    chk("ff_one_start", n_start0 - s0, 1);

    // Data_Valid held across 0x55 then 0xAA
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
    P_DATA = 8'h55; Data_Valid = 1'b1;
    tick();
    P_DATA = 8'hAA;
    for (int i = 0; i < 21; i++) begin
      tx_seq[20 - i] = tx[0];
      bz_seq[20 - i] = busy[0];
      if (i == 11) Data_Valid = 1'b0;
      tick();
    end
    chk("b2b_tx", 32'(tx_seq), 32'b010101010110010101011);
    chk("b2b_busy", 32'(bz_seq), 32'b111111111101111111111);
    wait_idle();
    tick();

    // Reset in DATA cycle 4, then a clean 0x81 frame
    frame(8'hC3, 1'b0, 1'b0);
    repeat (4) tick();
    chk("pre_rst_busy", 32'(busy), 32'd3);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'd3);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ser_en", 32'(ser_en), 32'd0);
    tick();
    #2 RST = 1'b0;
    tick();
    b0 = q0.size(); b1 = q1.size();
    frame(8'h81, 1'b0, 1'b0);
    wait_idle();
    chk("p81_len1", q1.size() - b1, 11);
    chk("p81_bits1", bits_of(1, b1), 32'b01000000111);
    chk("p81_bits0", bits_of(0, b0), 32'b0100000011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
